// File: rtl/width_conv_fifo_pkg.sv
// Shared helpers for the down-converting FIFO and its pointer controller.
// Latency: none (elaboration-time functions only).
// Backpressure: not applicable.
package width_conv_fifo_pkg;

    // $clog2 that never yields 0, so a one-value counter still gets one bit
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    // number of output chunks carried by one input word
    function automatic int chunks_of(input int in_w, input int out_w);
        return in_w / out_w;
    endfunction

    // storage address width; depth is always >= 2 so this is plain clog2
    function automatic int addr_w_of(input int depth);
        return clog2_min1(depth);
    endfunction

    // input must split into whole chunks and depth must be a power of two >= 2
    function automatic bit params_legal(input int in_w, input int out_w, input int depth);
        return (out_w > 0) && (in_w >= out_w) && ((in_w % out_w) == 0) &&
               (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/width_conv_fifo_if.sv
// Wide-in / narrow-out stream bundle for the down-converting FIFO.
// Latency: none (wiring only).
// Backpressure: s_ready throttles the producer, m_ready throttles the FIFO.
interface width_conv_fifo_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 4
);
    logic [IN_W-1:0]  s_data;
    logic             s_valid;
    logic             s_ready;
    logic [OUT_W-1:0] m_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_last;

    // FIFO side: accepts wide words, emits narrow chunks
    modport slave (
        input  s_data, s_valid, m_ready,
        output s_ready, m_data, m_valid, m_last
    );

    // environment side: producer of words and consumer of chunks
    modport master (
        output s_data, s_valid, m_ready,
        input  s_ready, m_data, m_valid, m_last
    );
endinterface

// File: rtl/width_conv_fifo_ptr_ctrl.sv
// Read/write pointer pair with wrap bit, full/empty, fill level and threshold flags.
// Latency: flags follow pointers combinationally, one cycle after the causing edge.
// Backpressure: caller must only push when !full and only pop_word when !empty.
module fifo_ptr_ctrl
    import width_conv_fifo_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int AFULL_MARGIN  = 1,
    parameter int AEMPTY_MARGIN = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop_word,
    output logic [$clog2(DEPTH)-1:0] wr_addr,
    output logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     almost_full,
    output logic                     almost_empty
);
    localparam int ADDR_W = addr_w_of(DEPTH);
    localparam int LVL_W  = ADDR_W + 1;
    localparam logic [LVL_W-1:0] AF_TH = LVL_W'(DEPTH - AFULL_MARGIN);
    localparam logic [LVL_W-1:0] AE_TH = LVL_W'(AEMPTY_MARGIN);

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;

    // pointers advance on accepted strobes; rst and flush both rewind them to 0
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_word) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    assign wr_addr      = wr_ptr[ADDR_W-1:0];
    assign rd_addr      = rd_ptr[ADDR_W-1:0];
    assign empty        = (wr_ptr == rd_ptr);
    assign full         = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                          (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    // modular difference is exact because the wrap bit doubles the pointer range
    assign level        = wr_ptr - rd_ptr;
    assign almost_full  = (level >= AF_TH);
    assign almost_empty = (level <= AE_TH);

endmodule

// File: rtl/width_conv_fifo.sv
// Down-converting FIFO: stores DEPTH wide words, emits OUT_W chunks LS-chunk first.
// Latency: a word written at edge N presents chunk 0 after edge N; no same-cycle pass-through.
// Backpressure: s_ready drops when full or flushing; chunk output holds while m_ready is low.
module width_conv_fifo
    import width_conv_fifo_pkg::*;
#(
    parameter int IN_W          = 16,
    parameter int OUT_W         = 4,
    parameter int DEPTH         = 4,
    parameter int AFULL_MARGIN  = 1,
    parameter int AEMPTY_MARGIN = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    width_conv_fifo_if.slave       bus,
    output logic [$clog2(DEPTH):0] level,
    output logic                   almost_full,
    output logic                   almost_empty
);
    localparam int CHUNKS = chunks_of(IN_W, OUT_W);
    localparam int CW     = clog2_min1(CHUNKS);
    localparam int ADDR_W = addr_w_of(DEPTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(CHUNKS - 1);

    if (!params_legal(IN_W, OUT_W, DEPTH)) begin : g_param_check
        $error("width_conv_fifo: illegal parameters IN_W=%0d OUT_W=%0d DEPTH=%0d",
               IN_W, OUT_W, DEPTH);
    end

    logic [IN_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              full;
    logic              empty;
    logic [CW-1:0]     chunk_idx;
    logic              s_rdy;
    logic              m_vld;
    logic              push;
    logic              pop;
    logic              on_last;
    logic              pop_word;

    // handshakes come from the pre-edge pointer state only
    assign s_rdy    = !full && !flush;
    assign m_vld    = !empty && !flush;
    assign push     = bus.s_valid && s_rdy;
    assign pop      = m_vld && bus.m_ready;
    assign on_last  = (chunk_idx == LAST_IDX);
    assign pop_word = pop && on_last;

    fifo_ptr_ctrl #(
        .DEPTH         (DEPTH),
        .AFULL_MARGIN  (AFULL_MARGIN),
        .AEMPTY_MARGIN (AEMPTY_MARGIN)
    ) u_ptr_ctrl (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .push         (push),
        .pop_word     (pop_word),
        .wr_addr      (wr_addr),
        .rd_addr      (rd_addr),
        .full         (full),
        .empty        (empty),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    // storage takes accepted words only and is deliberately left unreset
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_addr] <= bus.s_data;
        end
    end

    // chunk index steps per pop and wraps to 0 when the last chunk leaves
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            chunk_idx <= '0;
        end else if (pop) begin
            chunk_idx <= on_last ? '0 : chunk_idx + 1'b1;
        end
    end

    logic [IN_W-1:0]  rd_word;
    logic [OUT_W-1:0] chunk_arr [CHUNKS];

    assign rd_word = mem[rd_addr];

    for (genvar g = 0; g < CHUNKS; g++) begin : g_chunk
        assign chunk_arr[g] = rd_word[g*OUT_W +: OUT_W];
    end

    assign bus.s_ready = s_rdy;
    assign bus.m_valid = m_vld;
    assign bus.m_data  = m_vld ? chunk_arr[chunk_idx] : '0;
    assign bus.m_last  = m_vld && on_last;

endmodule

// File: doc/width_conv_fifo.md
# width_conv_fifo

Parametrised down-converting FIFO: accepts wide words on a valid/ready slave port, stores them in a DEPTH-entry buffer, and emits them as OUT_W-bit chunks, least-significant chunk first, on a valid/ready master port. It sits between the wide weight/activation fetch path and the narrow per-neuron datapath of the neural-net core. It adds flow-control handshakes, fill-level reporting, programmable almost-full/empty flags, per-word last-chunk marking and synchronous flush.

## Interface
Parameters:
- IN_W, 16, input word width; must be an integer multiple of OUT_W.
- OUT_W, 4, output chunk width.
- DEPTH, 4, storage depth in input words; power of two, ≥ 2.
- AFULL_MARGIN, 1, almost_full asserts when level ≥ DEPTH − AFULL_MARGIN.
- AEMPTY_MARGIN, 1, almost_empty asserts when level ≤ AEMPTY_MARGIN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of contents; lower priority than rst.
- s_data  in  IN_W  input word.
- s_valid  in  1  input word present.
- s_ready  out  1  FIFO can accept; write occurs when s_valid && s_ready.
- m_data  out  OUT_W  current output chunk; 0 when m_valid is low.
- m_valid  out  1  chunk available.
- m_ready  in  1  consumer accepts; pop occurs when m_valid && m_ready.
- m_last  out  1  current chunk is the final (most-significant) chunk of its word; 0 when m_valid is low.
- level  out  $clog2(DEPTH)+1  words held, including a partially read word.
- almost_full  out  1  threshold flag per AFULL_MARGIN.
- almost_empty  out  1  threshold flag per AEMPTY_MARGIN.

## Operation
- CHUNKS = IN_W/OUT_W. Chunk k of a word is bits [k·OUT_W +: OUT_W]; k = 0 is emitted first.
- Pointers: wr_ptr and rd_ptr are ADDR_W+1 bits, ADDR_W = $clog2(DEPTH). The extra bit is the wrap bit. The pointers wrap naturally modulo 2·DEPTH.
- Full and empty:
  - empty = (wr_ptr == rd_ptr).
  - full = address bits equal and wrap bits differ.
- level = wr_ptr − rd_ptr (modular).
- Handshake signals:
  - s_ready = !full && !flush.
  - m_valid = !empty && !flush.
- Chunk index chunk_idx ($clog2(CHUNKS) bits, minimum 1) advances on each pop. When the pop is on chunk CHUNKS−1, chunk_idx returns to 0 and rd_ptr increments.
- m_last = m_valid && (chunk_idx == CHUNKS−1).
- Output datapath: m_data is selected combinationally from the registered storage entry at rd_ptr[ADDR_W−1:0] using chunk_idx.
- Simultaneous write and pop are both performed. level changes only by (write) − (pop of a last chunk).
- Full with a last-chunk pop in the same cycle: the write is refused. s_ready is derived from the pre-edge state; there is no same-cycle pass-through.
- Empty: a write is not visible on the output in the same cycle.
- flush: rd_ptr, wr_ptr and chunk_idx clear to 0 at the edge. Any write or pop in that cycle is suppressed. Storage contents are not cleared.
- rst: same clearing as flush and takes precedence. Storage is not reset.
- Illegal parameters (IN_W % OUT_W ≠ 0, DEPTH not a power of two) stop elaboration with an error.

## Timing
- Reset or flush outputs, the cycle after the edge: s_ready 1, m_valid 0, m_data 0, m_last 0, level 0, almost_full 0 (for AFULL_MARGIN < DEPTH), almost_empty 1.
- Write-to-output latency: 1 cycle. A word accepted at edge N shows chunk 0 with m_valid=1 after edge N.
- Throughput:
  - Output: one chunk per cycle while m_ready is high.
  - Input: one word per cycle while not full.
- Sustained output stream requires an input rate ≥ 1 word per CHUNKS cycles.
- Pop-to-space latency: the pop of a last chunk at edge N raises s_ready after edge N when the FIFO was full.
- Backpressure: while m_valid && !m_ready, m_data, m_last and chunk_idx hold stable.
- Flags (level, almost_full, almost_empty) are combinational from the pointers and update in the cycle after the causing edge.

## Structure
- Package width_conv_fifo_pkg holds:
  - a clog2-with-minimum-1 function;
  - the CHUNKS/ADDR_W derivation constants;
  - a parameter-legality check function.
- Sub-module fifo_ptr_ctrl holds the pointer pair, full/empty/level computation and the threshold flags. It takes push/pop_word strobes and is reusable by the planned up-converting variant.
- The top level holds storage, chunk_idx, the chunk mux and the handshake gating.

## Test plan
1. **Single word.** Reset, then write 16'hA5C3 with m_ready=1.
   - m_valid rises next cycle; m_data is 3, C, 5, A on consecutive cycles; m_last is set only with A.
   - Then m_valid=0 and level=0.
2. **Fill.** Drive s_valid=1 continuously with m_ready=0 and words 16'h1111..16'h4444.
   - Four writes accepted; s_ready=0 after the 4th; level=4; almost_full=1.
   - The 5th word 16'h5555 is held off with no write.
3. **Full with concurrent pop and write.** From full, assert m_ready=1 and keep s_valid=1.
   - After the 4th chunk of 16'h1111, s_ready rises and 16'h5555 is accepted; level returns to 4.
   - wr_ptr wraps correctly; 16'h5555 is eventually read out as 5,5,5,5.
4. **Backpressure.** Mid-word, toggle m_ready in a 1-0-0-1 pattern.
   - m_data holds the same chunk across the stalled cycles; no chunk is skipped or duplicated.
5. **Flush mid-word.** Pulse flush after 2 chunks of 16'hBEEF (F, E) are popped.
   - m_valid=0 and level=0 next cycle.
   - A following write of 16'h0123 emits 3, 2, 1, 0, starting at chunk 0.
6. **Priority and mid-operation reset.** Assert rst with flush and s_valid high while 3 words are stored.
   - All outputs take their reset values.
   - Re-run scenario 1 with DEPTH=8, IN_W=32, OUT_W=8 to exercise the parametrisation.
